// File: rtl/amds_pkg.sv
// Shared types and constants for the AMDS frame receiver.
package amds_pkg;

  localparam int unsigned AMDS_CNT_W = 16;
  localparam int unsigned AMDS_MAX_CH = 8;
  localparam int unsigned AMDS_IDX_W = 5;
  localparam logic [7:0] AMDS_HEADER_DEFAULT = 8'h90;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COMMIT
  } frame_state_t;

  // Shadow byte slot for frame byte idx (>0): MSB/LSB pairs swap so that
  // byte slot 2k is the LSB and 2k+1 the MSB of channel k.
  function automatic logic [AMDS_IDX_W-1:0] shadow_slot(input logic [AMDS_IDX_W-1:0] idx);
    return (idx - AMDS_IDX_W'(1)) ^ AMDS_IDX_W'(1);
  endfunction

endpackage

// File: rtl/amds_frame_rx_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count events, hold at all-ones, clear on request.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/amds_frame_rx.sv
// AMDS frame receiver: sequences the byte receiver through one frame,
// checks the header, assembles 16-bit channel samples and counts events.
module amds_frame_rx
  import amds_pkg::*;
#(
  parameter int unsigned N_CH        = AMDS_MAX_CH,
  parameter logic [7:0]  HEADER_BYTE = AMDS_HEADER_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic                  clr_counts,
  output logic                  start_rx,
  input  logic                  is_byte_valid,
  input  logic                  is_byte_corrupt,
  input  logic                  byte_timed_out,
  input  logic [7:0]            din_byte,
  output logic [16*N_CH-1:0]    ch_data,
  output logic                  frame_valid,
  output logic                  busy,
  output logic [AMDS_CNT_W-1:0] cnt_frames,
  output logic [AMDS_CNT_W-1:0] cnt_corrupt,
  output logic [AMDS_CNT_W-1:0] cnt_timeout,
  output logic [AMDS_CNT_W-1:0] cnt_bad_hdr,
  output logic [AMDS_CNT_W-1:0] cnt_missed
);

  localparam int unsigned N_BYTES = 2 * N_CH;
  localparam logic [AMDS_IDX_W-1:0] LAST_IDX = AMDS_IDX_W'(N_BYTES);

  frame_state_t                state_q, state_d;
  logic [AMDS_IDX_W-1:0]       idx_q, idx_d;
  logic [AMDS_IDX_W-1:0]       slot;
  logic [N_BYTES-1:0][7:0]     shadow_q, shadow_d;
  logic                        load_ch;
  logic                        start_rx_d, frame_valid_d, busy_d;
  logic                        inc_frames, inc_corrupt, inc_timeout, inc_bad_hdr, inc_missed;

  // Next-state, shadow update and event decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    slot        = shadow_slot(idx_q);
    load_ch     = 1'b0;
    inc_frames  = 1'b0;
    inc_corrupt = 1'b0;
    inc_timeout = 1'b0;
    inc_bad_hdr = 1'b0;
    inc_missed  = trigger && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (byte_timed_out) begin
          inc_timeout = 1'b1;
          state_d     = ST_IDLE;
        end else if (is_byte_corrupt) begin
          inc_corrupt = 1'b1;
          state_d     = ST_IDLE;
        end else if (is_byte_valid) begin
          if ((idx_q == '0) && (din_byte != HEADER_BYTE)) begin
            inc_bad_hdr = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            if (idx_q != '0) begin
              for (int unsigned b = 0; b < N_BYTES; b++) begin
                if (slot == AMDS_IDX_W'(b)) begin
                  shadow_d[b] = din_byte;
                end
              end
            end
            if (idx_q == LAST_IDX) begin
              load_ch = 1'b1;
              state_d = ST_COMMIT;
            end else begin
              idx_d   = idx_q + AMDS_IDX_W'(1);
              state_d = ST_ISSUE;
            end
          end
        end
      end
      ST_COMMIT: begin
        inc_frames = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    start_rx_d    = (state_d == ST_ISSUE);
    frame_valid_d = load_ch;
    busy_d        = (state_d != ST_IDLE);
  end

  // State, shadow and registered outputs; ch_data loads with the last byte
  // merged so it appears together with frame_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      ch_data     <= '0;
      start_rx    <= 1'b0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      start_rx    <= start_rx_d;
      frame_valid <= frame_valid_d;
      busy        <= busy_d;
      if (load_ch) begin
        ch_data <= shadow_d;
      end
    end
  end

  sat_counter #(.W(AMDS_CNT_W)) u_cnt_frames (
    .clk(clk), .rst(rst), .inc(inc_frames), .clr(clr_counts), .count(cnt_frames)
  );
  sat_counter #(.W(AMDS_CNT_W)) u_cnt_corrupt (
    .clk(clk), .rst(rst), .inc(inc_corrupt), .clr(clr_counts), .count(cnt_corrupt)
  );
  sat_counter #(.W(AMDS_CNT_W)) u_cnt_timeout (
    .clk(clk), .rst(rst), .inc(inc_timeout), .clr(clr_counts), .count(cnt_timeout)
  );
  sat_counter #(.W(AMDS_CNT_W)) u_cnt_bad_hdr (
    .clk(clk), .rst(rst), .inc(inc_bad_hdr), .clr(clr_counts), .count(cnt_bad_hdr)
  );
  sat_counter #(.W(AMDS_CNT_W)) u_cnt_missed (
    .clk(clk), .rst(rst), .inc(inc_missed), .clr(clr_counts), .count(cnt_missed)
  );

endmodule

// File: tb/tb_amds_frame_rx.sv
// Bench for amds_frame_rx with N_CH=2: behavioural byte receiver, frame
// scoreboard and directed frame scenarios.
`timescale 1ns/1ps
module tb_amds_frame_rx;

  localparam int unsigned NCH = 2;

  logic        clk = 1'b0;
  logic        rst, trigger, clr_counts;
  logic        start_rx;
  logic        is_byte_valid, is_byte_corrupt, byte_timed_out;
  logic [7:0]  din_byte;
  logic [16*NCH-1:0] ch_data;
  logic        frame_valid, busy;
  logic [15:0] cnt_frames, cnt_corrupt, cnt_timeout, cnt_bad_hdr, cnt_missed;

  typedef struct {
    int         kind;   // 0 valid, 1 corrupt, 2 timeout
    logic [7:0] data;
    int         dly;
    int         chk;    // 0 none, 1 abort timing, 2 commit timing
  } rx_item_t;

  rx_item_t    rx_q[$];
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int st_cnt = 0;
  int fv_cnt = 0;
  int s0, f0;

  amds_frame_rx #(.N_CH(NCH), .HEADER_BYTE(8'h90)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .clr_counts(clr_counts),
    .start_rx(start_rx), .is_byte_valid(is_byte_valid),
    .is_byte_corrupt(is_byte_corrupt), .byte_timed_out(byte_timed_out),
    .din_byte(din_byte), .ch_data(ch_data), .frame_valid(frame_valid),
    .busy(busy), .cnt_frames(cnt_frames), .cnt_corrupt(cnt_corrupt),
    .cnt_timeout(cnt_timeout), .cnt_bad_hdr(cnt_bad_hdr), .cnt_missed(cnt_missed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] d, input int dly = 3, input int chk = 0);
    rx_item_t it;
    it.kind = kind; it.data = d; it.dly = dly; it.chk = chk;
    rx_q.push_back(it);
  endtask

  task automatic pulse_trigger(input bit chk_lat);
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    if (chk_lat) check("start_rx_latency", 32'(start_rx), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle_bound", 32'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_fv();
    int n = 0;
    while (!frame_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!frame_valid) check("wait_frame_valid_bound", 32'(frame_valid), 1);
  endtask

  task automatic check_counts(input string tag, input int fr, input int co, input int to,
                              input int bh, input int mi);
    check({tag, "_cnt_frames"},  32'(cnt_frames),  32'(fr));
    check({tag, "_cnt_corrupt"}, 32'(cnt_corrupt), 32'(co));
    check({tag, "_cnt_timeout"}, 32'(cnt_timeout), 32'(to));
    check({tag, "_cnt_bad_hdr"}, 32'(cnt_bad_hdr), 32'(bh));
    check({tag, "_cnt_missed"},  32'(cnt_missed),  32'(mi));
  endtask

  // Behavioural byte receiver: clears flags on start_rx, answers after dly cycles.
  initial begin
    rx_item_t it;
    is_byte_valid = 1'b0; is_byte_corrupt = 1'b0; byte_timed_out = 1'b0; din_byte = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (start_rx && !rst) begin
        is_byte_valid = 1'b0; is_byte_corrupt = 1'b0; byte_timed_out = 1'b0;
        if (rx_q.size() > 0) begin
          it = rx_q.pop_front();
          repeat (it.dly) @(posedge clk);
          #1;
          case (it.kind)
            0:       begin din_byte = it.data; is_byte_valid = 1'b1; end
            1:       is_byte_corrupt = 1'b1;
            default: byte_timed_out = 1'b1;
          endcase
          if (it.chk != 0) begin
            @(negedge clk);
            check("busy_before_flag_seen", 32'(busy), 1);
            @(negedge clk);
            if (it.chk == 1) begin
              check("busy_fall_abort", 32'(busy), 0);
            end else begin
              check("frame_valid_after_last", 32'(frame_valid), 1);
              check("busy_in_commit", 32'(busy), 1);
              @(negedge clk);
              check("busy_fall_commit", 32'(busy), 0);
            end
          end
        end
      end
    end
  end

  // Scoreboard monitor: every frame_valid pulse must match the next expected frame.
  always @(negedge clk) begin
    if (start_rx) st_cnt++;
    if (frame_valid) begin
      fv_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", ch_data, 32'h0);
        if (ch_data == 32'h0) begin
          errors++;
          $display("FAIL unexpected_frame: got frame_valid expected none at %0t", $time);
        end
      end else begin
        check("ch_data_frame", ch_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; trigger = 1'b0; clr_counts = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ch_data", ch_data, 0);
    check("rst_frame_valid", 32'(frame_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start_rx", 32'(start_rx), 0);
    check_counts("rst", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Good frame
    push(0, 8'h90); push(0, 8'h12); push(0, 8'h34); push(0, 8'hAB); push(0, 8'hCD, 3, 2);
    exp_q.push_back(32'hABCD_1234);
    s0 = st_cnt; f0 = fv_cnt;
    pulse_trigger(1'b1);
    wait_idle();
    check("good_start_pulses", 32'(st_cnt - s0), 5);
    check("good_fv_pulses", 32'(fv_cnt - f0), 1);
    check("good_ch_data", ch_data, 32'hABCD_1234);
    check_counts("good", 1, 0, 0, 0, 0);

    // Bad header
    push(0, 8'h91);
    s0 = st_cnt;
    pulse_trigger(1'b0);
    wait_idle();
    check("badhdr_start_pulses", 32'(st_cnt - s0), 1);
    check("badhdr_ch_data", ch_data, 32'hABCD_1234);
    check_counts("badhdr", 1, 0, 0, 1, 0);

    // Corrupt on byte 3
    push(0, 8'h90); push(0, 8'h11); push(0, 8'h22); push(1, 8'h00, 3, 1);
    s0 = st_cnt;
    pulse_trigger(1'b0);
    wait_idle();
    check("corrupt_start_pulses", 32'(st_cnt - s0), 4);
    check("corrupt_ch_data", ch_data, 32'hABCD_1234);
    check_counts("corrupt", 1, 1, 0, 1, 0);

    // Timeout on byte 0
    push(2, 8'h00, 4, 1);
    pulse_trigger(1'b0);
    wait_idle();
    check("timeout_ch_data", ch_data, 32'hABCD_1234);
    check_counts("timeout", 1, 1, 1, 1, 0);

    // Trigger mid-frame and on the COMMIT cycle are both dropped
    push(0, 8'h90); push(0, 8'h01); push(0, 8'h02); push(0, 8'h03); push(0, 8'h04, 3, 2);
    exp_q.push_back(32'h0304_0102);
    s0 = st_cnt;
    pulse_trigger(1'b0);
    repeat (10) @(negedge clk);
    pulse_trigger(1'b0);
    wait_fv();
    trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    wait_idle();
    check("missed_start_pulses", 32'(st_cnt - s0), 5);
    check("missed_ch_data", ch_data, 32'h0304_0102);
    check_counts("missed", 2, 1, 1, 1, 2);

    // clr_counts together with COMMIT wins over the frame increment
    push(0, 8'h90); push(0, 8'hAA); push(0, 8'hBB); push(0, 8'hCC); push(0, 8'hDD, 3, 2);
    exp_q.push_back(32'hCCDD_AABB);
    pulse_trigger(1'b0);
    wait_fv();
    clr_counts = 1'b1;
    @(negedge clk) clr_counts = 1'b0;
    wait_idle();
    check("clr_ch_data", ch_data, 32'hCCDD_AABB);
    check_counts("clr", 0, 0, 0, 0, 0);

    // Bad header so the reset has a nonzero counter to clear
    push(0, 8'h00);
    pulse_trigger(1'b0);
    wait_idle();
    check_counts("prerst", 0, 0, 0, 1, 0);

    // Reset while waiting on byte 2
    push(0, 8'h90); push(0, 8'h55); push(0, 8'h66, 20, 0);
    s0 = st_cnt;
    pulse_trigger(1'b0);
    for (int n = 0; n < 200 && st_cnt < s0 + 3; n++) @(negedge clk);
    check("rst_reached_byte2", 32'(st_cnt - s0), 3);
    repeat (3) @(negedge clk);
    check("midframe_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ch_data", ch_data, 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_frame_valid", 32'(frame_valid), 0);
    check("midrst_start_rx", 32'(start_rx), 0);
    check_counts("midrst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_counts("postrst_idle", 0, 0, 0, 0, 0);

    push(0, 8'h90); push(0, 8'h5A); push(0, 8'hA5); push(0, 8'hC3); push(0, 8'h3C, 3, 2);
    exp_q.push_back(32'hC33C_5AA5);
    s0 = st_cnt;
    pulse_trigger(1'b1);
    wait_idle();
    check("postrst_start_pulses", 32'(st_cnt - s0), 5);
    check("postrst_ch_data", ch_data, 32'hC33C_5AA5);
    check_counts("postrst", 1, 0, 0, 0, 0);

    check("exp_queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amds_frame_rx.md
# amds_frame_rx

Frame-level receiver sitting directly downstream of the per-byte UART receiver in the AMDS interface. On each sampling trigger it sequences the byte receiver through one full AMDS frame: it issues one `start_rx` per byte and consumes each byte's valid, corrupt or timed-out result. It checks the header and assembles per-channel 16-bit ADC samples. Complete frames are published to the AXI register layer; bad frames are counted and dropped.

## Interface
Parameters:
- `N_CH`, 8, channels per frame, legal range 1..8
- `HEADER_BYTE`, 8'h90, required value of byte 0

Ports:
- `clk`  in  1  system clock, 200 MHz
- `rst`  in  1  synchronous, active-high reset
- `trigger`  in  1  one-cycle pulse that requests a frame
- `clr_counts`  in  1  synchronous clear of all error and frame counters
- `start_rx`  out  1  one-cycle pulse to the byte receiver
- `is_byte_valid`  in  1  level from the byte receiver; cleared by the receiver on `start_rx`
- `is_byte_corrupt`  in  1  level from the byte receiver; parity failure
- `byte_timed_out`  in  1  level from the byte receiver; no start bit seen
- `din_byte`  in  8  received byte; stable while `is_byte_valid` is high
- `ch_data`  out  16*N_CH  last good frame; channel k occupies bits [16k+15:16k]
- `frame_valid`  out  1  one-cycle pulse when `ch_data` updates
- `busy`  out  1  high in any state other than IDLE
- `cnt_frames`, `cnt_corrupt`, `cnt_timeout`, `cnt_bad_hdr`, `cnt_missed`  out  16 each  saturating event counters

## Operation
Frame format:
- Bytes are received in order: header, then for each channel k an MSB byte and an LSB byte.
- Frame length L = 1 + 2·N_CH bytes.
- Byte index `idx` is 5 bits wide. Index 2k+1 is the MSB of channel k; index 2k+2 is the LSB.

State machine (IDLE, ISSUE, WAIT, COMMIT):
- **IDLE:** on `trigger`, set `idx` to 0 and go to ISSUE.
- **ISSUE:** drive `start_rx`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** evaluate the flags in this priority order:
  - `byte_timed_out`: increment `cnt_timeout`, go to IDLE.
  - `is_byte_corrupt`: increment `cnt_corrupt`, go to IDLE.
  - `is_byte_valid` with `idx`==0 and `din_byte`≠HEADER_BYTE: increment `cnt_bad_hdr`, go to IDLE.
  - `is_byte_valid` otherwise: store the byte into the shadow register (when `idx`>0). If `idx`==L−1, go to COMMIT; else increment `idx` and go to ISSUE.
  - No flag set: stay in WAIT. There is no local timeout; the byte receiver guarantees a result within 520 cycles.
- **COMMIT:** copy shadow to `ch_data`, pulse `frame_valid`, increment `cnt_frames`, go to IDLE.

Aborted frames:
- An aborted frame never modifies `ch_data`.
- The shadow register may hold partial data after an abort; it is never exposed.

Trigger while busy:
- A `trigger` arriving while `busy` is high is dropped and increments `cnt_missed`.
- A `trigger` in the same cycle as the COMMIT→IDLE or WAIT→IDLE transition counts as busy and is dropped.

Counters:
- All counters saturate at 16'hFFFF.
- `clr_counts` zeroes every counter and takes priority over any increment in the same cycle.

Reset (`rst`):
- State goes to IDLE and `idx` to 0.
- All outputs go to 0, including `ch_data` and every counter.
- Reset mid-frame abandons the frame silently; no counter increments.

## Timing
- `trigger` high at cycle T gives `start_rx` at T+1. Flags are first sampled at T+2; by then the byte receiver has already cleared its stale flags.
- Per byte: one ISSUE cycle plus the wait time.
- Inter-byte turnaround: a valid flag seen at cycle t gives the next `start_rx` at t+1.
- Completion: the last valid byte seen at cycle t gives `ch_data` updated and `frame_valid` high at t+1, and `busy` low at t+2.
- All outputs are registered.

## Structure
- Package `amds_pkg` holds:
  - the state enum `frame_state_t`
  - `AMDS_HEADER_DEFAULT`
  - `AMDS_CNT_W` (16)
  - `AMDS_MAX_CH` (8)
- Sub-module `sat_counter`: parameterised width, with `inc` and `clr` inputs, `clr` having priority. It is instantiated five times.
- Top level integration: `amds_frame_rx` and the byte receiver are instantiated side by side in the AXI wrapper.

## Test plan
- **Good frame, N_CH=2:** header 8'h90, bytes 12 34 AB CD, delivered via a behavioural byte-receiver model → `ch_data`=32'hABCD_1234, one `frame_valid` pulse, `cnt_frames`=1, `start_rx` pulsed exactly 5 times.
- **Bad header:** first byte 8'h91 → `cnt_bad_hdr`=1, `ch_data` unchanged, no second `start_rx`.
- **Error abort:** corrupt flag on byte 3 → `cnt_corrupt`=1. Timeout flag on byte 0 → `cnt_timeout`=1. `busy` falls the cycle after each flag is seen.
- **Missed trigger:** second `trigger` 10 cycles into a frame → `cnt_missed`=1, that frame still completes. `clr_counts` asserted together with a COMMIT → all counters 0.
- **Reset mid-frame:** `rst` pulsed while in WAIT at byte 2 → all outputs 0 the next cycle. A following good frame completes normally.
